// File: rtl/counter_pkg.sv
// counter_pkg: direction/mode encodings and the bounded step rule shared by counter instances
package counter_pkg;

    typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_e;
    typedef enum logic {MODE_SAT = 1'b0, MODE_WRAP = 1'b1} mode_e;

    typedef struct packed {
        logic [31:0] count;
        logic        wrapped;
    } next_t;

    // Operands are zero-extended counts; the 33-bit sum keeps full-range bounds free of overflow.
    function automatic next_t next_count(input logic [31:0] count, input logic [31:0] lower,
                                         input logic [31:0] upper, input logic [31:0] step,
                                         input dir_e dir, input mode_e mode);
        logic [32:0] sum;
        logic        hit;
        next_t       r;
        sum = {1'b0, count} + {1'b0, step};
        hit = (dir == DIR_UP) ? (count >= upper || sum > {1'b0, upper})
                              : (count <= lower || {1'b0, count} < {1'b0, lower} + {1'b0, step});
        r.count   = hit ? (((dir == DIR_UP) ^ (mode == MODE_WRAP)) ? upper : lower)
                        : ((dir == DIR_UP) ? sum[31:0] : count - step);
        r.wrapped = hit & (mode == MODE_WRAP);
        return r;
    endfunction

endpackage

// File: rtl/clock_enable_divider.sv
// clock_enable_divider: emits tick on every PRESCALE-th enabled cycle; phase holds while disabled
module clock_enable_divider #(
    parameter int PRESCALE = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] phase;

    assign tick = enable & (phase == LAST);

    always_ff @(posedge clock) begin
        if (reset || clear)
            phase <= '0;
        else if (enable)
            phase <= (phase == LAST) ? '0 : phase + 1'b1;
    end

endmodule

// File: rtl/bounded_updown_counter.sv
// bounded_updown_counter: up/down counter with runtime bounds, wrap/saturate, load and prescaled enable
module bounded_updown_counter
    import counter_pkg::*;
#(
    parameter int               WIDTH       = 10,
    parameter int               INCREMENT   = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               PRESCALE    = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             up,
    input  logic             wrap_mode,
    input  logic [WIDTH-1:0] lower_bound,
    input  logic [WIDTH-1:0] upper_bound,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count_value,
    output logic             terminal,
    output logic             carry_out,
    output logic             wrap_pulse,
    output logic             config_error
);

    localparam logic [WIDTH-1:0] STEP = WIDTH'(INCREMENT);

    logic  tick;
    next_t nxt;

    clock_enable_divider #(.PRESCALE(PRESCALE)) u_div (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .clear  (load),
        .tick   (tick)
    );

    assign config_error = lower_bound > upper_bound;
    assign terminal     = up ? (count_value >= upper_bound) : (count_value <= lower_bound);
    // Cascade enable for a downstream counter; suppressed while load overrides the tick.
    assign carry_out    = tick & terminal & wrap_mode & ~config_error & ~load;
    assign nxt          = next_count(32'(count_value), 32'(lower_bound), 32'(upper_bound), 32'(STEP),
                                     dir_e'(up), mode_e'(wrap_mode));

    always_ff @(posedge clock) begin
        if (reset) begin
            count_value <= RESET_VALUE;
            wrap_pulse  <= 1'b0;
        end else if (load) begin
            count_value <= load_value;
            wrap_pulse  <= 1'b0;
        end else if (tick && !config_error) begin
            count_value <= WIDTH'(nxt.count);
            wrap_pulse  <= nxt.wrapped;
        end else begin
            wrap_pulse  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bounded_updown_counter.sv
// tb_bounded_updown_counter: directed scenarios plus randomized run against an arithmetic reference model
module tb_bounded_updown_counter;

    logic       clock = 1'b0;
    logic       reset, enable, up, wrap_mode, load;
    logic [3:0] lower_bound, upper_bound, load_value;
    logic [3:0] c1, c3, cp;
    logic       t1, t3, tp, co1, co3, cop, wp1, wp3, wpp, ce1, ce3, cep;
    int         passed = 0, total = 0;

    always #5 clock = ~clock;

    bounded_updown_counter #(.WIDTH(4), .INCREMENT(1), .RESET_VALUE(4'd7), .PRESCALE(1)) d1 (
        .clock(clock), .reset(reset), .enable(enable), .up(up), .wrap_mode(wrap_mode),
        .lower_bound(lower_bound), .upper_bound(upper_bound), .load(load), .load_value(load_value),
        .count_value(c1), .terminal(t1), .carry_out(co1), .wrap_pulse(wp1), .config_error(ce1));

    bounded_updown_counter #(.WIDTH(4), .INCREMENT(3), .RESET_VALUE(4'd0), .PRESCALE(1)) d3 (
        .clock(clock), .reset(reset), .enable(enable), .up(up), .wrap_mode(wrap_mode),
        .lower_bound(lower_bound), .upper_bound(upper_bound), .load(load), .load_value(load_value),
        .count_value(c3), .terminal(t3), .carry_out(co3), .wrap_pulse(wp3), .config_error(ce3));

    bounded_updown_counter #(.WIDTH(4), .INCREMENT(1), .RESET_VALUE(4'd0), .PRESCALE(3)) dp (
        .clock(clock), .reset(reset), .enable(enable), .up(up), .wrap_mode(wrap_mode),
        .lower_bound(lower_bound), .upper_bound(upper_bound), .load(load), .load_value(load_value),
        .count_value(cp), .terminal(tp), .carry_out(cop), .wrap_pulse(wpp), .config_error(cep));

    task automatic edge_;
        @(posedge clock);
        #1;
    endtask

    task automatic do_load(input int v);
        load = 1'b1; load_value = 4'(v); enable = 1'b0;
        edge_();
        load = 1'b0;
    endtask

    // Reference step: plain integer arithmetic on the bounded range.
    function automatic void ref_step(input int c, input int inc, input bit u, input bit w,
                                     input int lo, input int hi, output int nc, output bit wr);
        nc = c; wr = 1'b0;
        if (lo > hi) return;
        if (u) begin
            if (c + inc > hi) begin nc = w ? lo : hi; wr = w; end
            else nc = c + inc;
        end else begin
            if (c - inc < lo) begin nc = w ? hi : lo; wr = w; end
            else nc = c - inc;
        end
    endfunction

    task automatic test_reset;
        reset = 1'b1; load = 1'b0; enable = 1'b1;
        edge_();
        total++; if (c1 !== 4'd7) $display("FAIL reset c1 got %0d exp 7", c1); else passed++;
        total++; if (c3 !== 4'd0 || cp !== 4'd0) $display("FAIL reset c3/cp got %0d/%0d exp 0/0", c3, cp); else passed++;
        total++; if (wp1 !== 1'b0) $display("FAIL reset wp1 got %b exp 0", wp1); else passed++;
        reset = 1'b0; enable = 1'b0;
    endtask

    task automatic test_wrap_up;
        int exp_c[5] = '{3, 4, 5, 2, 3};
        lower_bound = 4'd2; upper_bound = 4'd5; up = 1'b1; wrap_mode = 1'b1;
        do_load(2);
        for (int i = 0; i < 5; i++) begin
            enable = 1'b1;
            @(negedge clock);
            total++; if (co1 !== (i == 3)) $display("FAIL wrap_up carry cyc%0d got %b exp %b", i, co1, i == 3); else passed++;
            edge_();
            total++; if (c1 !== 4'(exp_c[i])) $display("FAIL wrap_up count cyc%0d got %0d exp %0d", i, c1, exp_c[i]); else passed++;
            total++; if (wp1 !== (i == 3)) $display("FAIL wrap_up pulse cyc%0d got %b exp %b", i, wp1, i == 3); else passed++;
        end
        enable = 1'b0;
    endtask

    task automatic test_saturate_down;
        int exp_c[4] = '{1, 0, 0, 0};
        int prev = 2;
        lower_bound = 4'd0; upper_bound = 4'd15; up = 1'b0; wrap_mode = 1'b0;
        do_load(2);
        for (int i = 0; i < 4; i++) begin
            enable = 1'b1;
            @(negedge clock);
            total++; if (t1 !== (prev == 0)) $display("FAIL sat_down terminal cyc%0d got %b exp %b", i, t1, prev == 0); else passed++;
            edge_();
            total++; if (c1 !== 4'(exp_c[i])) $display("FAIL sat_down count cyc%0d got %0d exp %0d", i, c1, exp_c[i]); else passed++;
            total++; if (wp1 !== 1'b0) $display("FAIL sat_down pulse cyc%0d got %b exp 0", i, wp1); else passed++;
            prev = exp_c[i];
        end
        enable = 1'b0;
    endtask

    task automatic test_full_range_inc3;
        lower_bound = 4'd0; upper_bound = 4'd15; up = 1'b1; wrap_mode = 1'b1;
        do_load(13);
        enable = 1'b1;
        edge_();
        total++; if (c3 !== 4'd0 || wp3 !== 1'b1) $display("FAIL inc3 wrap got %0d/%b exp 0/1", c3, wp3); else passed++;
        edge_();
        total++; if (c3 !== 4'd3 || wp3 !== 1'b0) $display("FAIL inc3 next got %0d/%b exp 3/0", c3, wp3); else passed++;
        enable = 1'b0;
    endtask

    task automatic test_prescale;
        int exp_c[11] = '{0, 0, 1, 1, 1, 2, 2, 2, 2, 2, 3};
        bit en_pat[11] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 1, 1};
        lower_bound = 4'd0; upper_bound = 4'd15; up = 1'b1; wrap_mode = 1'b1;
        do_load(0);
        for (int i = 0; i < 11; i++) begin
            enable = en_pat[i];
            edge_();
            total++; if (cp !== 4'(exp_c[i])) $display("FAIL prescale count cyc%0d got %0d exp %0d", i + 1, cp, exp_c[i]); else passed++;
        end
        enable = 1'b0;
    endtask

    task automatic test_priority;
        reset = 1'b1; load = 1'b1; load_value = 4'd9; enable = 1'b1;
        edge_();
        total++; if (c1 !== 4'd7) $display("FAIL prio reset_load got %0d exp 7", c1); else passed++;
        reset = 1'b0;
        lower_bound = 4'd2; upper_bound = 4'd5; up = 1'b1; wrap_mode = 1'b1;
        do_load(5);
        load = 1'b1; load_value = 4'd3; enable = 1'b1;
        @(negedge clock);
        total++; if (co1 !== 1'b0) $display("FAIL prio load_carry got %b exp 0", co1); else passed++;
        edge_();
        total++; if (c1 !== 4'd3 || wp1 !== 1'b0) $display("FAIL prio load_tick got %0d/%b exp 3/0", c1, wp1); else passed++;
        load = 1'b0; enable = 1'b0;
    endtask

    task automatic test_config_error;
        lower_bound = 4'd9; upper_bound = 4'd4; up = 1'b1; wrap_mode = 1'b1;
        do_load(6);
        total++; if (c1 !== 4'd6) $display("FAIL cfg load got %0d exp 6", c1); else passed++;
        for (int i = 0; i < 3; i++) begin
            enable = 1'b1;
            @(negedge clock);
            total++; if (ce1 !== 1'b1 || co1 !== 1'b0) $display("FAIL cfg flags cyc%0d got %b/%b exp 1/0", i, ce1, co1); else passed++;
            edge_();
            total++; if (c1 !== 4'd6 || wp1 !== 1'b0) $display("FAIL cfg hold cyc%0d got %0d/%b exp 6/0", i, c1, wp1); else passed++;
        end
        lower_bound = 4'd0; upper_bound = 4'd15;
        edge_();
        total++; if (c1 !== 4'd7 || ce1 !== 1'b0) $display("FAIL cfg resume got %0d/%b exp 7/0", c1, ce1); else passed++;
        enable = 1'b0;
    endtask

    task automatic test_random;
        int m1 = 0, m3 = 0, mp = 0, mph = 0, lo, hi, nc;
        bit p1 = 0, p3 = 0, pp = 0, wr, term, ptick;
        reset = 1'b1; load = 1'b0; edge_();
        reset = 1'b0; m1 = 7;
        for (int it = 0; it < 400; it++) begin
            reset = ($urandom_range(0, 49) == 0);
            load = ($urandom_range(0, 9) == 0);
            enable = ($urandom_range(0, 9) < 7);
            up = 1'($urandom); wrap_mode = 1'($urandom);
            load_value = 4'($urandom);
            lower_bound = 4'($urandom_range(0, 8));
            upper_bound = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'($urandom_range(7, 15));
            lo = int'(lower_bound); hi = int'(upper_bound);
            @(negedge clock);
            term = up ? (m1 >= hi) : (m1 <= lo);
            ptick = enable && (mph == 2);
            total++; if (ce1 !== (lo > hi)) $display("FAIL rand cfg it%0d got %b exp %b", it, ce1, lo > hi); else passed++;
            total++; if (t1 !== term) $display("FAIL rand terminal it%0d got %b exp %b", it, t1, term); else passed++;
            total++; if (co1 !== (enable && term && wrap_mode && lo <= hi && !load))
                $display("FAIL rand carry1 it%0d got %b exp %b", it, co1, enable && term && wrap_mode && lo <= hi && !load); else passed++;
            term = up ? (mp >= hi) : (mp <= lo);
            total++; if (cop !== (ptick && term && wrap_mode && lo <= hi && !load))
                $display("FAIL rand carryp it%0d got %b exp %b", it, cop, ptick && term && wrap_mode && lo <= hi && !load); else passed++;
            edge_();
            if (reset) begin
                m1 = 7; m3 = 0; mp = 0; mph = 0; p1 = 0; p3 = 0; pp = 0;
            end else if (load) begin
                m1 = lo == lo ? int'(load_value) : 0; m3 = int'(load_value); mp = int'(load_value);
                mph = 0; p1 = 0; p3 = 0; pp = 0;
            end else begin
                p1 = 0; p3 = 0; pp = 0;
                if (enable) begin
                    ref_step(m1, 1, up, wrap_mode, lo, hi, nc, wr); m1 = nc; p1 = wr;
                    ref_step(m3, 3, up, wrap_mode, lo, hi, nc, wr); m3 = nc; p3 = wr;
                    if (mph == 2) begin
                        ref_step(mp, 1, up, wrap_mode, lo, hi, nc, wr); mp = nc; pp = wr; mph = 0;
                    end else mph++;
                end
            end
            total++; if (c1 !== 4'(m1) || wp1 !== p1) $display("FAIL rand d1 it%0d got %0d/%b exp %0d/%b", it, c1, wp1, m1, p1); else passed++;
            total++; if (c3 !== 4'(m3) || wp3 !== p3) $display("FAIL rand d3 it%0d got %0d/%b exp %0d/%b", it, c3, wp3, m3, p3); else passed++;
            total++; if (cp !== 4'(mp) || wpp !== pp) $display("FAIL rand dp it%0d got %0d/%b exp %0d/%b", it, cp, wpp, mp, pp); else passed++;
        end
        reset = 1'b0; load = 1'b0; enable = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; up = 1'b1; wrap_mode = 1'b0; load = 1'b0;
        lower_bound = 4'd0; upper_bound = 4'd15; load_value = 4'd0;
        #1;
        test_reset();
        test_wrap_up();
        test_saturate_down();
        test_full_range_inc3();
        test_prescale();
        test_priority();
        test_config_error();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
